// File: rtl/mic_frame_buffer.sv
// Sample history buffer emitting an N-sample frame every HOP samples; drop counter under MIC_FRAME_DROPCNT_EN.
// Latency: frame_valid rises on the edge that registers the completing sample.
// Backpressure: valid/ready output slot; a completion while the slot is full is dropped and flagged.
module mic_frame_buffer #(
    parameter int SAMPLE_W = 32,
    parameter int N        = 8,
    parameter int HOP      = 8
) (
    input  logic                  adc_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   in_sample,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic [N*SAMPLE_W-1:0] frame_data,
    output logic                  overrun,
    output logic [7:0]            drop_count
);
    localparam int CW = $clog2(N);

    typedef enum logic {FILL, RUN} state_t;

    state_t                state;
    logic [CW-1:0]         fill_cnt;
    logic [CW-1:0]         hop_cnt;
    logic [N*SAMPLE_W-1:0] hist;
    logic [N*SAMPLE_W-1:0] hist_next;
    logic                  complete;
    logic                  slot_free;

    // Newest sample lands in slice 0; the frame is taken from the post-shift view.
    assign hist_next = {hist[(N-1)*SAMPLE_W-1:0], in_sample};

    assign complete  = in_valid &&
                       (((state == FILL) && (fill_cnt == CW'(N - 1))) ||
                        ((state == RUN)  && (hop_cnt  == CW'(HOP - 1))));
    assign slot_free = !frame_valid || frame_ready;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            hist        <= '0;
            state       <= FILL;
            fill_cnt    <= '0;
            hop_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            overrun     <= 1'b0;
        end else begin
            if (in_valid) begin
                hist <= hist_next;
                case (state)
                    FILL: begin
                        if (fill_cnt == CW'(N - 1)) begin
                            state    <= RUN;
                            fill_cnt <= '0;
                            hop_cnt  <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        hop_cnt <= (hop_cnt == CW'(HOP - 1)) ? '0 : hop_cnt + CW'(1);
                    end
                    default: state <= FILL;
                endcase
            end

            if (complete && slot_free) begin
                frame_valid <= 1'b1;
                frame_data  <= hist_next;
            end else begin
                if (frame_valid && frame_ready)
                    frame_valid <= 1'b0;
                if (complete)
                    overrun <= 1'b1;
            end
        end
    end

`ifdef MIC_FRAME_DROPCNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge adc_clk) begin
        if (reset)
            drop_q <= 8'd0;
        else if (complete && !slot_free && (drop_q != 8'hFF))
            drop_q <= drop_q + 8'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Two buffers (HOP=8 and HOP=4, N=8) share one stimulus stream and are checked against a sample-list model.
module tb_mic_frame_buffer;
    localparam int SW = 32;
    localparam int NN = 8;
    localparam int FW = NN * SW;

    logic          adc_clk;
    logic          reset;
    logic          in_valid;
    logic [SW-1:0] in_sample;
    logic          frame_ready;

    logic          fv [2];
    logic [FW-1:0] fd [2];
    logic          ov [2];
    logic [7:0]    dc [2];

    int total = 0;
    int bad   = 0;

    mic_frame_buffer #(.SAMPLE_W(SW), .N(NN), .HOP(8)) dut_h8 (
        .adc_clk(adc_clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
        .frame_ready(frame_ready), .frame_valid(fv[0]), .frame_data(fd[0]),
        .overrun(ov[0]), .drop_count(dc[0])
    );

    mic_frame_buffer #(.SAMPLE_W(SW), .N(NN), .HOP(4)) dut_h4 (
        .adc_clk(adc_clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
        .frame_ready(frame_ready), .frame_valid(fv[1]), .frame_data(fd[1]),
        .overrun(ov[1]), .drop_count(dc[1])
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    // Model: list of samples accepted since reset; a frame completes whenever the
    // count reaches N and then every further HOP samples.
    int            hops [2] = '{8, 4};
    logic [SW-1:0] samp [$];
    logic          ev  [2] = '{1'b0, 1'b0};
    logic [FW-1:0] ed  [2] = '{'0, '0};
    logic          eo  [2] = '{1'b0, 1'b0};
    int            edc [2] = '{0, 0};
    logic          run_cmp = 1'b0;

    always @(posedge adc_clk) begin
        if (reset) begin
            samp.delete();
            for (int h = 0; h < 2; h++) begin
                ev[h] = 1'b0; ed[h] = '0; eo[h] = 1'b0; edc[h] = 0;
            end
        end else begin
            if (in_valid) samp.push_back(in_sample);
            for (int h = 0; h < 2; h++) begin
                int sz;
                logic comp;
                sz   = samp.size();
                comp = in_valid && (sz >= NN) && (((sz - NN) % hops[h]) == 0);
                if (comp && (!ev[h] || frame_ready)) begin
                    ev[h] = 1'b1;
                    for (int k = 0; k < NN; k++) ed[h][k*SW +: SW] = samp[sz-1-k];
                end else begin
                    if (ev[h] && frame_ready) ev[h] = 1'b0;
                    if (comp) begin
                        eo[h] = 1'b1;
                        if (edc[h] < 255) edc[h] = edc[h] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_dc(input int v);
`ifdef MIC_FRAME_DROPCNT_EN
        return 8'(v);
`else
        return 8'd0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge adc_clk);
            #2;
            if (run_cmp) begin
                for (int h = 0; h < 2; h++) begin
                    chk($sformatf("m%0d_valid", h), FW'(fv[h]), FW'(ev[h]));
                    chk($sformatf("m%0d_data", h), fd[h], ed[h]);
                    chk($sformatf("m%0d_overrun", h), FW'(ov[h]), FW'(eo[h]));
                    chk($sformatf("m%0d_drops", h), FW'(dc[h]), FW'(exp_dc(edc[h])));
                end
            end
        end
    end

    // Hand-computed literal frame: slice k holds top-k.
    task automatic chk_frame(input string name, input int h, input int top);
        logic [FW-1:0] e;
        for (int k = 0; k < NN; k++) e[k*SW +: SW] = SW'(top - k);
        chk(name, fd[h], e);
    endtask

    task automatic send(input int v);
        in_valid  = 1'b1;
        in_sample = SW'(v);
        @(negedge adc_clk);
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge adc_clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge adc_clk);
        reset    = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sample   = '0;
        frame_ready = 1'b0;
        repeat (2) @(negedge adc_clk);
        reset   = 1'b0;
        run_cmp = 1'b1;

        for (int h = 0; h < 2; h++) begin
            chk($sformatf("rst_valid_%0d", h), FW'(fv[h]), '0);
            chk($sformatf("rst_data_%0d", h), fd[h], '0);
            chk($sformatf("rst_ovr_%0d", h), FW'(ov[h]), '0);
            chk($sformatf("rst_drops_%0d", h), FW'(dc[h]), '0);
        end

        // Streaming with the consumer always ready.
        frame_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            send(v);
            if (v == 4)  chk("h4_no_frame_at_4", FW'(fv[1]), '0);
            if (v == 8) begin
                chk("h8_valid_at_8", FW'(fv[0]), FW'(1));
                chk_frame("h8_frame_8", 0, 8);
                chk_frame("h4_frame_8", 1, 8);
            end
            if (v == 9)  chk("h8_valid_one_cycle", FW'(fv[0]), '0);
            if (v == 12) chk_frame("h4_frame_12", 1, 12);
            if (v == 16) begin
                chk("h8_valid_at_16", FW'(fv[0]), FW'(1));
                chk_frame("h8_frame_16", 0, 16);
            end
        end
        idle(2);

        // Consumer stalled: first frame held, later completions dropped, gaps harmless.
        do_reset();
        frame_ready = 1'b0;
        for (int v = 1; v <= 20; v++) begin
            send(v);
            if (v == 9) begin
                idle(1);
                send(100);
                idle(2);
                chk_frame("h4_held_in_gap", 1, 8);
            end
        end
        chk_frame("h4_held_after_20", 1, 8);
        chk_frame("h8_held_after_20", 0, 8);
        chk("h4_overrun", FW'(ov[1]), FW'(1));
        chk("h4_drops_3", FW'(dc[1]), FW'(exp_dc(3)));
        chk("h8_drops_1", FW'(dc[0]), FW'(exp_dc(1)));
        frame_ready = 1'b1;
        @(negedge adc_clk);
        frame_ready = 1'b0;
        chk("h4_taken", FW'(fv[1]), '0);
        idle(1);

        // Accept and completion on the same edge.
        do_reset();
        for (int v = 1; v <= 11; v++) send(v);
        frame_ready = 1'b1;
        send(12);
        frame_ready = 1'b0;
        chk("h4_reload_valid", FW'(fv[1]), FW'(1));
        chk_frame("h4_reload_frame", 1, 12);
        chk("h4_reload_no_ovr", FW'(ov[1]), '0);
        chk("h8_accepted", FW'(fv[0]), '0);
        idle(2);

        // Reset with a pending frame and overrun, then mid-fill.
        do_reset();
        for (int v = 1; v <= 12; v++) send(v);
        do_reset();
        chk("rst_clears_ovr", FW'(ov[1]), '0);
        chk("rst_clears_valid", FW'(fv[1]), '0);
        for (int v = 1; v <= 5; v++) send(v);
        do_reset();
        for (int v = 101; v <= 108; v++) begin
            send(v);
            if (v == 104) chk("h4_no_leak_104", FW'(fv[1]), '0);
        end
        chk_frame("h8_after_reset", 0, 108);
        chk_frame("h4_after_reset", 1, 108);
        chk("ovr_after_reset", FW'(ov[0]), '0);
        idle(3);

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
